// File: rtl/memory_access.sv
// Memory-access pipeline stage: runs one request/acknowledge transaction per instruction
// against a variable-latency data memory, with lane steering, load extension and bus timeout.
module memory_access #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memSize,
  input  logic        memUnsigned,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memByteEn,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memAck,
  output logic [31:0] resultOutput,
  output logic        done,
  output logic        busy,
  output logic        misaligned,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] COUNT_LIMIT = 8'(TIMEOUT - 1);

  state_t     state_r;
  logic [7:0] counter_r;
  logic       isWrite_r;
  logic [1:0] size_r;
  logic       unsigned_r;
  logic [1:0] offset_r;
  logic       isMem_s;
  logic       misalign_s;

  function automatic logic [3:0] laneEnable(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] en;
    case (size)
      2'b00:   en = 4'b0001 << offset;
      2'b01:   en = offset[1] ? 4'b1100 : 4'b0011;
      default: en = 4'b1111;
    endcase
    return en;
  endfunction

  function automatic logic [31:0] laneData(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      2'b00:   lanes = {4{data[7:0]}};
      2'b01:   lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

  // Selects the addressed lane of the read word and extends it to 32 bits.
  function automatic logic [31:0] formatLoad(input logic [1:0] size, input logic isUnsigned,
                                             input logic [1:0] offset, input logic [31:0] rdata);
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] value;
    case (offset)
      2'b00:   byteSel = rdata[7:0];
      2'b01:   byteSel = rdata[15:8];
      2'b10:   byteSel = rdata[23:16];
      default: byteSel = rdata[31:24];
    endcase
    halfSel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00: begin
        if (isUnsigned) value = {24'd0, byteSel};
        else            value = {{24{byteSel[7]}}, byteSel};
      end
      2'b01: begin
        if (isUnsigned) value = {16'd0, halfSel};
        else            value = {{16{halfSel[15]}}, halfSel};
      end
      default: value = rdata;
    endcase
    return value;
  endfunction

  // Classifies the incoming instruction: memory access or not, and alignment for its size.
  always_comb begin
    isMem_s    = memRead | memWrite;
    misalign_s = 1'b0;
    if (isMem_s) begin
      case (memSize)
        2'b00:   misalign_s = 1'b0;
        2'b01:   misalign_s = address[0];
        default: misalign_s = |address[1:0];
      endcase
    end else begin
      misalign_s = 1'b0;
    end
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      counter_r    <= 8'd0;
      isWrite_r    <= 1'b0;
      size_r       <= 2'b00;
      unsigned_r   <= 1'b0;
      offset_r     <= 2'b00;
      memReq       <= 1'b0;
      memWe        <= 1'b0;
      memAddr      <= 32'd0;
      memByteEn    <= 4'd0;
      memWdata     <= 32'd0;
      resultOutput <= 32'd0;
      done         <= 1'b0;
      busy         <= 1'b0;
      misaligned   <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy       <= 1'b1;
            misaligned <= 1'b0;
            timeout    <= 1'b0;
            isWrite_r  <= memWrite;
            size_r     <= memSize;
            unsigned_r <= memUnsigned;
            offset_r   <= address[1:0];
            memAddr    <= {address[31:2], 2'b00};
            memByteEn  <= laneEnable(memSize, address[1:0]);
            memWdata   <= laneData(memSize, writeData);
            if (misalign_s) begin
              misaligned   <= 1'b1;
              resultOutput <= 32'd0;
              done         <= 1'b1;
              state_r      <= DONE;
            end else if (!isMem_s) begin
              resultOutput <= address;
              done         <= 1'b1;
              state_r      <= DONE;
            end else begin
              memReq    <= 1'b1;
              memWe     <= memWrite;
              counter_r <= 8'd0;
              state_r   <= ACCESS;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ACCESS: begin
          // An ack in the final allowed cycle takes precedence over the timeout.
          if (memAck) begin
            memReq       <= 1'b0;
            memWe        <= 1'b0;
            done         <= 1'b1;
            resultOutput <= isWrite_r ? 32'd0 : formatLoad(size_r, unsigned_r, offset_r, memRdata);
            state_r      <= DONE;
          end else if (counter_r == COUNT_LIMIT) begin
            memReq       <= 1'b0;
            memWe        <= 1'b0;
            done         <= 1'b1;
            timeout      <= 1'b1;
            resultOutput <= 32'd0;
            state_r      <= DONE;
          end else begin
            counter_r <= counter_r + 8'd1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          memReq  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          memReq  <= 1'b0;
          memWe   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for memory_access: a byte-level reference model predicts lanes,
// results, flags and latency for each instruction, compared cycle by cycle.
module tb_memory_access;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  memSize;
  logic        memUnsigned;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memByteEn;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic        memAck;
  logic [31:0] resultOutput;
  logic        done;
  logic        busy;
  logic        misaligned;
  logic        timeout;

  int assertCount = 0;
  int failCount   = 0;

  memory_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .memRead(memRead), .memWrite(memWrite),
    .memSize(memSize), .memUnsigned(memUnsigned), .address(address), .writeData(writeData),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memByteEn(memByteEn),
    .memWdata(memWdata), .memRdata(memRdata), .memAck(memAck), .resultOutput(resultOutput),
    .done(done), .busy(busy), .misaligned(misaligned), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: works in bytes and offsets rather than lane encodings.
  task automatic refModel(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                          input int ackAt, output logic bus, output logic mis, output logic tmo,
                          output logic [3:0] en, output logic [31:0] wd, output logic [31:0] res);
    int nBytes;
    int off;
    logic isMem;
    logic [31:0] mask;
    logic [31:0] val;
    nBytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off    = int'(addr % 32'd4);
    isMem  = rd | wr;
    mis    = isMem && ((addr % nBytes) != 0);
    bus    = isMem && !mis;
    tmo    = 1'b0;
    en     = 4'(((1 << nBytes) - 1) << off);
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % nBytes) +: 8];
    if (!isMem) res = addr;
    else if (mis) res = 32'd0;
    else if (ackAt == 0) begin
      res = 32'd0;
      tmo = 1'b1;
    end else if (wr) res = 32'd0;
    else begin
      mask = (nBytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nBytes)) - 32'd1);
      val  = (rdata >> (8 * off)) & mask;
      if (!uns && nBytes < 4 && val[8*nBytes-1]) val = val | ~mask;
      res = val;
    end
  endtask

  // One instruction from start to the idle cycle after done; ackAt=0 means never ack.
  task automatic runTxn(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        input int ackAt);
    logic bus, mis, tmo;
    logic [3:0] en;
    logic [31:0] wd, res;
    int last;
    refModel(rd, wr, size, uns, addr, wdata, rdata, ackAt, bus, mis, tmo, en, wd, res);
    start = 1'b1; memRead = rd; memWrite = wr; memSize = size; memUnsigned = uns;
    address = addr; writeData = wdata;
    memAck = 1'($urandom_range(0, 1));
    memRdata = $urandom;
    tick();
    start = 1'b0; memAck = 1'b0;
    checkValue("busyAfterStart", 32'(busy), 32'd1);
    if (bus) begin
      checkValue("misClear", 32'(misaligned), 32'd0);
      checkValue("tmoClear", 32'(timeout), 32'd0);
      last = (ackAt == 0) ? TO : ackAt;
      for (int c = 1; c <= last; c++) begin
        checkValue("memReq", 32'(memReq), 32'd1);
        checkValue("memWe", 32'(memWe), 32'(wr));
        checkValue("memAddr", memAddr, {addr[31:2], 2'b00});
        checkValue("memByteEn", 32'(memByteEn), 32'(en));
        checkValue("memWdata", memWdata, wd);
        checkValue("doneEarly", 32'(done), 32'd0);
        if (c == ackAt) begin
          memAck = 1'b1;
          memRdata = rdata;
        end
        tick();
        memAck = 1'b0;
        memRdata = $urandom;
      end
    end
    checkValue("done", 32'(done), 32'd1);
    checkValue("memReqInDone", 32'(memReq), 32'd0);
    checkValue("busyInDone", 32'(busy), 32'd1);
    checkValue("result", resultOutput, res);
    checkValue("misaligned", 32'(misaligned), 32'(mis));
    checkValue("timeout", 32'(timeout), 32'(tmo));
    start = 1'($urandom_range(0, 1));
    memAck = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0; memAck = 1'b0;
    checkValue("donePulse", 32'(done), 32'd0);
    checkValue("busyIdle", 32'(busy), 32'd0);
    checkValue("memReqIdle", 32'(memReq), 32'd0);
    checkValue("resultHeld", resultOutput, res);
    checkValue("misHeld", 32'(misaligned), 32'(mis));
    checkValue("tmoHeld", 32'(timeout), 32'(tmo));
  endtask

  initial begin
    logic rd, wr;
    logic [31:0] a;
    reset = 1'b1; start = 1'b0; memRead = 1'b0; memWrite = 1'b0; memSize = 2'b00;
    memUnsigned = 1'b0; address = 32'd0; writeData = 32'd0; memRdata = 32'd0; memAck = 1'b0;
    tick();
    tick();
    checkValue("rstReq", 32'(memReq), 32'd0);
    checkValue("rstWe", 32'(memWe), 32'd0);
    checkValue("rstAddr", memAddr, 32'd0);
    checkValue("rstEn", 32'(memByteEn), 32'd0);
    checkValue("rstWdata", memWdata, 32'd0);
    checkValue("rstResult", resultOutput, 32'd0);
    checkValue("rstFlags", {28'd0, done, busy, misaligned, timeout}, 32'd0);
    reset = 1'b0;
    tick();

    runTxn(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_1234, 32'd0, 32'd0, 1);
    runTxn(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'd0, 32'h80AA_BBCC, 3);
    runTxn(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'd0, 32'h80AA_BBCC, 3);
    runTxn(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 32'd0, 1);
    runTxn(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'd0, 32'd0, 1);
    runTxn(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 32'hCAFE_F00D, 2);
    runTxn(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 32'h1111_2222, 0);
    runTxn(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 32'h3333_4444, TO);
    runTxn(1'b1, 1'b1, 2'd3, 1'b0, 32'h0000_0204, 32'h5555_6666, 32'd0, 2);

    // Asynchronous reset during the second bus cycle.
    start = 1'b1; memRead = 1'b1; memWrite = 1'b0; memSize = 2'd2; address = 32'h0000_0300;
    tick();
    start = 1'b0;
    tick();
    #1 reset = 1'b1;
    #1;
    checkValue("midRstReq", 32'(memReq), 32'd0);
    checkValue("midRstBusy", 32'(busy), 32'd0);
    checkValue("midRstDone", 32'(done), 32'd0);
    reset = 1'b0;
    tick();
    checkValue("postRstDone", 32'(done), 32'd0);
    runTxn(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'd0, 32'hDEAD_BEEF, 2);

    for (int n = 0; n < 200; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = $urandom;
      if (!rd && !wr) runTxn(1'b0, 1'b0, 2'd0, 1'($urandom_range(0, 1)), a, $urandom, $urandom, 1);
      else runTxn(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                  int'($urandom_range(0, TO)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/memory_access.md
# memory_access

Memory-access stage placed directly downstream of the execute stage. It takes the execute result as the effective address (or passes it through for non-memory instructions) and the second register operand as store data. It then runs a request/acknowledge transaction with a variable-latency data memory, handling byte/halfword/word lanes, load extension, misalignment and bus timeout. While the transaction is outstanding it holds `busy` high so the control unit stalls the PC. It produces the write-back value with a one-cycle `done` pulse.

## Interface
- `TIMEOUT`, default 64: maximum number of cycles `memReq` stays high without `memAck` (legal range 1..255).
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `start` input, 1 bit: execute result valid; begins the access for the current instruction. Ignored unless in IDLE.
- `memRead` input, 1 bit: instruction is a load.
- `memWrite` input, 1 bit: instruction is a store. Takes priority over `memRead` if both are set.
- `memSize` input, 2 bits: 00 = byte, 01 = half, 10/11 = word.
- `memUnsigned` input, 1 bit: load is zero-extended (lbu/lhu); otherwise sign-extended.
- `address` input, 32 bits: execute-stage result (effective address or ALU result).
- `writeData` input, 32 bits: store data (second register operand).
- `memReq` output, 1 bit: bus request, held until acknowledge or timeout.
- `memWe` output, 1 bit: write strobe, valid while `memReq` is high.
- `memAddr` output, 32 bits: word-aligned address `{address[31:2], 2'b00}`.
- `memByteEn` output, 4 bits: active byte lanes; bit i = bits [8i+7:8i].
- `memWdata` output, 32 bits: lane-replicated store data.
- `memRdata` input, 32 bits: read data, valid in the `memAck` cycle.
- `memAck` input, 1 bit: transaction complete. May be asserted in the same cycle `memReq` first rises.
- `resultOutput` output, 32 bits: write-back value, held stable from the `done` pulse until the next `done`.
- `done` output, 1 bit: one-cycle pulse, result valid.
- `busy` output, 1 bit: high from the cycle after `start` is accepted through the `done` cycle inclusive.
- `misaligned` output, 1 bit: address-error flag, valid with `done`, held until the next accepted `start`.
- `timeout` output, 1 bit: bus-timeout flag, valid with `done`, held until the next accepted `start`.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE, `start`=1:** latch all inputs. Clear `misaligned` and `timeout`. Then:
  - half access with `address[0]`=1, or word access with `address[1:0]`≠0: set `misaligned`, go to DONE, `resultOutput`=0, no bus cycle.
  - neither read nor write: go to DONE, `resultOutput`=`address`.
  - otherwise: go to ACCESS and clear the timeout counter.
- **ACCESS:** `memReq`=1 and `memWe`=latched write.
  - On `memAck`: go to DONE. Loads capture and format `memRdata`; stores set `resultOutput`=0.
  - On no ack with counter = `TIMEOUT`-1: set `timeout`, `resultOutput`=0, go to DONE. `memReq` falls on entry to DONE.
  - On no ack otherwise: increment the counter.
  - If `memAck` arrives in the same cycle the counter reaches its limit, the ack wins and `timeout` stays 0.
- **DONE:** `done`=1 for this cycle only, `memReq`=0, then return to IDLE. A `start` in DONE is ignored; the control unit re-asserts it.
- **Lane rules (little-endian):**
  - Byte: `memByteEn`=1<<`address[1:0]`, `memWdata`={4{`writeData[7:0]`}}, load takes lane `address[1:0]`.
  - Half: `memByteEn`=`address[1]` ? 1100 : 0011, `memWdata`={2{`writeData[15:0]`}}, load takes the upper or lower half.
  - Word: `memByteEn`=1111, `memWdata`=`writeData`.
- Byte and half loads extend to 32 bits: zero-extend if `memUnsigned`, else sign-extend from bit 7 or bit 15.
- `memAck` outside ACCESS is ignored.

## Timing
- Reset (asynchronous): state IDLE and counter 0; every output low or zero. That covers `memReq`, `memWe`, `memAddr`, `memByteEn`, `memWdata`, `resultOutput`, `done`, `busy`, `misaligned` and `timeout`.
- Reset asserted mid-ACCESS drops `memReq` immediately (asynchronous); no `done` is produced.
- Non-memory or misaligned instruction: `start` in cycle 0, `done` in cycle 1.
- Load or store: `start` in cycle 0, `memReq` in cycles 1..k, with `memAck` in cycle k; `done` in cycle k+1. Minimum latency is 2 cycles.
- Timeout: `memReq` is high for exactly `TIMEOUT` cycles; `done` and `timeout` are both high in the following cycle.
- `memAddr`, `memByteEn`, `memWdata` and `memWe` are registered and stay stable for every cycle in which `memReq` is high.

## Test plan
- `start`, non-memory instruction, `address`=0x0000_1234 -> `done` in cycle 1, `resultOutput`=0x0000_1234, `memReq` never rises.
- `lb`, `address`=0x103, `memRdata`=0x80AA_BBCC, ack in cycle 3 -> `memByteEn`=1000, `done` in cycle 4, `resultOutput`=0xFFFF_FF80. The same access as `lbu` -> 0x0000_0080.
- `sh`, `address`=0x102, `writeData`=0x1234_ABCD, immediate ack -> `memByteEn`=1100, `memWdata`=0xABCD_ABCD, `memAddr`=0x100, `memWe`=1, `done` in cycle 2.
- `lw`, `address`=0x101 -> `misaligned`=1 and `done` in cycle 1, no bus cycle. The flag clears on the next accepted `start`.
- `TIMEOUT`=4, no ack -> `memReq` high for 4 cycles, then `done`=1, `timeout`=1, `resultOutput`=0. A second run with ack in the 4th cycle -> `timeout`=0.
- Reset in the 2nd ACCESS cycle -> `memReq`, `busy` and `done` are 0 immediately. A later `start` with `lw` at 0x200 completes normally.
